// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns an EX/MEM access into a req/ack bus transaction and stalls until done.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse bus_err instead.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_mem,
  input  logic              MemWrite_mem,
  input  logic [2:0]        funct3_mem,
  input  logic [ADDR_W-1:0] ALUResult_mem,
  input  logic [31:0]       MemWriteData_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       MemDout_mem,
  output logic              Stall_mem,
  output logic              bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              load_q, load_d;
  logic              bus_req_d, bus_we_d, bus_err_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [31:0]       bus_wdata_d, dout_d;
  logic [3:0]        bus_wstrb_d;

  logic              access, is_b, is_h, trap;
  logic [1:0]        off;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  always_comb begin
    access = MemRead_mem | MemWrite_mem;
    off    = ALUResult_mem[1:0];
    is_b   = (funct3_mem == 3'b000) || (funct3_mem == 3'b100);
    is_h   = (funct3_mem == 3'b001) || (funct3_mem == 3'b101);
`ifdef MISALIGN_TRAP_EN
    trap   = is_h ? off[0] : (!is_b && (off != 2'b00));
`else
    trap   = 1'b0;
`endif
    if (is_b) begin
      st_wdata = {4{MemWriteData_mem[7:0]}};
      st_wstrb = 4'b0001 << off;
    end else if (is_h) begin
      st_wdata = {2{MemWriteData_mem[15:0]}};
      st_wstrb = 4'b0011 << {off[1], 1'b0};
    end else begin
      st_wdata = MemWriteData_mem;
      st_wstrb = 4'b1111;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    f3_d        = f3_q;
    off_d       = off_q;
    load_d      = load_q;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_wstrb_d = bus_wstrb;
    dout_d      = MemDout_mem;
    bus_err_d   = 1'b0;
    Stall_mem   = 1'b0;
    case (state)
      ST_IDLE: begin
        Stall_mem = access;
        if (access && trap) begin
          dout_d    = '0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else if (access) begin
          bus_req_d   = 1'b1;
          bus_we_d    = MemWrite_mem;
          bus_addr_d  = {ALUResult_mem[ADDR_W-1:2], 2'b00};
          bus_wdata_d = st_wdata;
          bus_wstrb_d = MemWrite_mem ? st_wstrb : 4'b0000;
          cnt_d       = '0;
          f3_d        = funct3_mem;
          off_d       = off;
          load_d      = MemRead_mem;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        Stall_mem = 1'b1;
        if (bus_ack) begin
          bus_req_d   = 1'b0;
          bus_wstrb_d = '0;
          if (load_q) dout_d = fmt_load(f3_q, off_q, bus_rdata);
          state_d     = ST_DONE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_req_d   = 1'b0;
          bus_wstrb_d = '0;
          dout_d      = '0;
          bus_err_d   = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      MemDout_mem <= '0;
      bus_err     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      load_q      <= load_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      bus_wstrb   <= bus_wstrb_d;
      MemDout_mem <= dout_d;
      bus_err     <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset/timeout sequences, random model check.
module tb_mem_access_unit;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_mem, MemWrite_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] ALUResult_mem, MemWriteData_mem;
  logic        bus_req, bus_we, bus_ack, Stall_mem, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, MemDout_mem;
  logic [3:0]  bus_wstrb;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
    .funct3_mem(funct3_mem), .ALUResult_mem(ALUResult_mem), .MemWriteData_mem(MemWriteData_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .MemDout_mem(MemDout_mem),
    .Stall_mem(Stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] addr, data, rdata;
    int unsigned delay;   // WAIT cycle carrying bus_ack (1 = first); 0 = never acked
    bit          trap;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata, e_dout;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] cur_dout = 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata,
                              input int unsigned delay, input logic [31:0] e_addr,
                              input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                              input logic [31:0] e_dout);
    vec_t v;
    v.ld = ld; v.f3 = f3; v.addr = addr; v.data = data; v.rdata = rdata; v.delay = delay;
    v.trap = 1'b0; v.e_addr = e_addr; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_dout = e_dout;
    return v;
  endfunction

  // Reference: sizes, lanes and extension worked out arithmetically from the access rules.
  function automatic vec_t model(input vec_t vin, input logic [31:0] prev);
    vec_t v;
    int unsigned size, lane;
    logic [31:0] mask, val;
    bit sgn, mis;
    v = vin;
    size = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
    sgn  = (v.f3 == 3'd0 || v.f3 == 3'd1);
    lane = (size == 1) ? int'(v.addr % 4) : (size == 2) ? int'(v.addr % 4) / 2 * 2 : 0;
    mis  = (size == 2 && (v.addr % 2) != 0) || (size == 4 && (v.addr % 4) != 0);
`ifdef MISALIGN_TRAP_EN
    v.trap = mis;
`else
    v.trap = 1'b0;
    if (mis) v.trap = 1'b0;
`endif
    v.e_addr  = v.addr / 4 * 4;
    v.e_wstrb = v.ld ? 4'd0 : 4'(((1 << size) - 1) << lane);
    v.e_wdata = (size == 1) ? (v.data & 32'hFF) * 32'h01010101 :
                (size == 2) ? (v.data & 32'hFFFF) * 32'h00010001 : v.data;
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    val  = (v.rdata >> (8 * lane)) & mask;
    if (sgn && ((val >> (8 * size - 1)) & 32'h1) != 0) val = val | ~mask;
    if (v.trap || v.delay == 0) v.e_dout = 32'h0;
    else if (v.ld)              v.e_dout = val;
    else                        v.e_dout = prev;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int unsigned stalls;
    bit hold_ok, tmo;
    tmo = (v.delay == 0 || v.delay > T);
    MemRead_mem = v.ld; MemWrite_mem = !v.ld; funct3_mem = v.f3;
    ALUResult_mem = v.addr; MemWriteData_mem = v.data;
    #1;
    chk("idle_stall", {31'h0, Stall_mem}, 32'h1);
    stalls = Stall_mem ? 1 : 0;
    step();
    if (v.trap) begin
      chk("trap_req", {31'h0, bus_req}, 32'h0);
      chk("trap_err", {31'h0, bus_err}, 32'h1);
      chk("trap_stall", {31'h0, Stall_mem}, 32'h0);
    end else begin
      chk("req", {31'h0, bus_req}, 32'h1);
      chk("addr", bus_addr, v.e_addr);
      chk("we", {31'h0, bus_we}, {31'h0, !v.ld});
      chk("wstrb", {28'h0, bus_wstrb}, {28'h0, v.e_wstrb});
      if (!v.ld) chk("wdata", bus_wdata, v.e_wdata);
      hold_ok = 1'b1;
      for (int unsigned i = 1; i <= T; i++) begin
        if (bus_req !== 1'b1 || bus_addr !== v.e_addr || bus_wstrb !== v.e_wstrb) hold_ok = 1'b0;
        if (Stall_mem === 1'b1) stalls++;
        bus_rdata = (i == v.delay) ? v.rdata : $urandom;
        bus_ack   = (i == v.delay);
        step();
        bus_ack = 1'b0;
        if (i == v.delay) break;
      end
      chk("wait_hold", {31'h0, hold_ok}, 32'h1);
      chk("stall_cycles", stalls, tmo ? T + 1 : v.delay + 1);
      chk("done_req", {31'h0, bus_req}, 32'h0);
      chk("done_wstrb", {28'h0, bus_wstrb}, 32'h0);
      chk("done_stall", {31'h0, Stall_mem}, 32'h0);
      chk("done_err", {31'h0, bus_err}, {31'h0, tmo});
    end
    chk("dout", MemDout_mem, v.e_dout);
    cur_dout = v.e_dout;
    MemRead_mem = 1'b0; MemWrite_mem = 1'b0;
    step();
    chk("err_one_cycle", {31'h0, bus_err}, 32'h0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    reset = 1'b0; MemRead_mem = 1'b0; MemWrite_mem = 1'b0; funct3_mem = 3'd0;
    ALUResult_mem = 32'h0; MemWriteData_mem = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

    //           ld f3    addr        data          rdata         dly addr        wstrb    wdata         dout
    tbl[0]  = mk(1, 3'd2, 32'h10, 32'h0,         32'hDEADBEEF, 2, 32'h10, 4'b0000, 32'h0,         32'hDEADBEEF);
    tbl[1]  = mk(1, 3'd0, 32'h13, 32'h0,         32'h80123456, 1, 32'h10, 4'b0000, 32'h0,         32'hFFFFFF80);
    tbl[2]  = mk(1, 3'd4, 32'h13, 32'h0,         32'h80123456, 1, 32'h10, 4'b0000, 32'h0,         32'h00000080);
    tbl[3]  = mk(1, 3'd5, 32'h12, 32'h0,         32'h80123456, 1, 32'h10, 4'b0000, 32'h0,         32'h00008012);
    tbl[4]  = mk(0, 3'd1, 32'h22, 32'h0000ABCD,  32'hFFFFFFFF, 1, 32'h20, 4'b1100, 32'hABCDABCD,  32'h00008012);
    tbl[5]  = mk(0, 3'd0, 32'h31, 32'h123456A5,  32'hFFFFFFFF, 3, 32'h30, 4'b0010, 32'hA5A5A5A5,  32'h00008012);
    tbl[6]  = mk(0, 3'd2, 32'h44, 32'hCAFEF00D,  32'h0,        1, 32'h44, 4'b1111, 32'hCAFEF00D,  32'h00008012);
    tbl[7]  = mk(1, 3'd1, 32'h50, 32'h0,         32'h1234F00D, 3, 32'h50, 4'b0000, 32'h0,         32'hFFFFF00D);
    tbl[8]  = mk(1, 3'd1, 32'h52, 32'h0,         32'h80007FFF, 1, 32'h50, 4'b0000, 32'h0,         32'hFFFF8000);
    tbl[9]  = mk(1, 3'd0, 32'h60, 32'h0,         32'h0000007F, 2, 32'h60, 4'b0000, 32'h0,         32'h0000007F);
    tbl[10] = mk(1, 3'd3, 32'h70, 32'h0,         32'h13572468, 1, 32'h70, 4'b0000, 32'h0,         32'h13572468);
    tbl[11] = mk(1, 3'd2, 32'h80, 32'h0,         32'h0,        0, 32'h80, 4'b0000, 32'h0,         32'h0);

    step(); step();
    chk("rst_req", {31'h0, bus_req}, 32'h0);
    chk("rst_dout", MemDout_mem, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_stall", {31'h0, Stall_mem}, 32'h0);
    reset = 1'b1;
    step();

    foreach (tbl[k]) run_txn(tbl[k]);

    // Reset in the middle of WAIT, followed by a stray ack.
    MemRead_mem = 1'b1; funct3_mem = 3'd2; ALUResult_mem = 32'h90;
    step(); step(); step();
    chk("pre_rst_req", {31'h0, bus_req}, 32'h1);
    reset = 1'b0; MemRead_mem = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_req", {31'h0, bus_req}, 32'h0);
    chk("midrst_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("midrst_wdata", bus_wdata, 32'h0);
    chk("midrst_dout", MemDout_mem, 32'h0);
    chk("midrst_stall", {31'h0, Stall_mem}, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    step();
    bus_ack = 1'b0;
    chk("stray_ack_req", {31'h0, bus_req}, 32'h0);
    chk("stray_ack_dout", MemDout_mem, 32'h0);
    chk("stray_ack_err", {31'h0, bus_err}, 32'h0);
    chk("stray_ack_stall", {31'h0, Stall_mem}, 32'h0);
    cur_dout = 32'h0;

    // Misaligned word load: trapped with the macro, truncated to 0x04 without it.
    v = mk(1, 3'd2, 32'h06, 32'h0, 32'h11223344, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    v = model(v, cur_dout);
    run_txn(v);

    for (int unsigned r = 0; r < 60; r++) begin
      v.ld    = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: v.f3 = 3'd0; 1: v.f3 = 3'd1; 2: v.f3 = 3'd2;
        3: v.f3 = v.ld ? 3'd4 : 3'd0; 4: v.f3 = v.ld ? 3'd5 : 3'd1;
        default: v.f3 = v.ld ? 3'd7 : 3'd2;
      endcase
      v.addr  = $urandom & 32'hFFFF_FFFF;
      v.data  = $urandom;
      v.rdata = $urandom;
      v.delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      v = model(v, cur_dout);
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
